// File: rtl/axil_arbiter_priority_wr.sv
// axil_arbiter_priority_wr
// Fixed-priority write-path arbiter for the AXI-Lite priority interconnect.
// The lowest-indexed requesting master wins and keeps the grant across the
// AW, W and B channels until the slave's write response has been accepted by
// that master. aw_open / w_open let the write muxes forward at most one AW
// and one W beat per grant.
//
// Ports:
//   aclk, aresetn    clock, synchronous active-low reset
//   request_wr       per-master write request (AW or W pending)
//   grant_wr         one-hot grant (registered)
//   grant_wr_idx     binary index of granted master, 0 when idle (registered)
//   aw_open, w_open  granted master's AW / W handshake still permitted
//   m_axil_awvalid, s_axil_awready   AW channel handshake signals
//   m_axil_wvalid,  s_axil_wready    W channel handshake signals
//   s_axil_bvalid,  m_axil_bready    B channel handshake signals
module axil_arbiter_priority_wr #(
  parameter int NUMBER_MASTER = 4
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUMBER_MASTER-1:0]         request_wr,
  output logic [NUMBER_MASTER-1:0]         grant_wr,
  output logic [$clog2(NUMBER_MASTER)-1:0] grant_wr_idx,
  output logic                             aw_open,
  output logic                             w_open,
  input  logic [NUMBER_MASTER-1:0]         m_axil_awvalid,
  input  logic                             s_axil_awready,
  input  logic [NUMBER_MASTER-1:0]         m_axil_wvalid,
  input  logic                             s_axil_wready,
  input  logic                             s_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0]         m_axil_bready
);

  localparam int IDX_W = $clog2(NUMBER_MASTER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic               aw_done;
  logic               w_done;

  logic [NUMBER_MASTER-1:0] pick_onehot;
  logic [IDX_W-1:0]         pick_idx;
  logic                     aw_hs;
  logic                     w_hs;
  logic                     b_hs;

  // Lowest set bit of request_wr. Scanning from the top down lets the
  // lowest index overwrite any higher one.
  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    for (int unsigned i = NUMBER_MASTER; i > 0; i--) begin
      if (request_wr[i-1]) begin
        pick_onehot      = '0;
        pick_onehot[i-1] = 1'b1;
        pick_idx         = IDX_W'(i-1);
      end
    end
  end

  // Only the granted master's handshakes are observed.
  always_comb begin
    aw_hs = m_axil_awvalid[grant_wr_idx] & s_axil_awready & ~aw_done;
    w_hs  = m_axil_wvalid[grant_wr_idx]  & s_axil_wready  & ~w_done;
    b_hs  = s_axil_bvalid & m_axil_bready[grant_wr_idx];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state        <= IDLE;
      grant_wr     <= '0;
      grant_wr_idx <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|request_wr) begin
            grant_wr     <= pick_onehot;
            grant_wr_idx <= pick_idx;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            state        <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) & (w_done | w_hs)) state <= RESP;
        end
        RESP: begin
          if (b_hs) begin
            grant_wr     <= '0;
            grant_wr_idx <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Derived purely from registered state, so glitch-free for the muxes.
  assign aw_open = (state == ADDR) & ~aw_done;
  assign w_open  = (state == ADDR) & ~w_done;

endmodule

// File: tb/tb_axil_arbiter_priority_wr.sv
module tb_axil_arbiter_priority_wr;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [N-1:0]  request_wr;
  logic [N-1:0]  grant_wr;
  logic [IW-1:0] grant_wr_idx;
  logic          aw_open;
  logic          w_open;
  logic [N-1:0]  m_axil_awvalid;
  logic          s_axil_awready;
  logic [N-1:0]  m_axil_wvalid;
  logic          s_axil_wready;
  logic          s_axil_bvalid;
  logic [N-1:0]  m_axil_bready;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus and which beats it has delivered.
  int owner   = -1;
  bit got_aw  = 1'b0;
  bit got_w   = 1'b0;

  always #5 aclk = ~aclk;

  axil_arbiter_priority_wr #(.NUMBER_MASTER(N)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .request_wr     (request_wr),
    .grant_wr       (grant_wr),
    .grant_wr_idx   (grant_wr_idx),
    .aw_open        (aw_open),
    .w_open         (w_open),
    .m_axil_awvalid (m_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .m_axil_wvalid  (m_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bvalid  (s_axil_bvalid),
    .m_axil_bready  (m_axil_bready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] awv, input logic awr,
                       input logic [N-1:0] wv, input logic wr, input logic bv,
                       input logic [N-1:0] br);
    request_wr     = req;
    m_axil_awvalid = awv;
    s_axil_awready = awr;
    m_axil_wvalid  = wv;
    s_axil_wready  = wr;
    s_axil_bvalid  = bv;
    m_axil_bready  = br;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_edge();
    if (!aresetn) begin
      owner = -1; got_aw = 1'b0; got_w = 1'b0;
    end else if (owner < 0) begin
      for (int i = 0; i < N; i++) begin
        if (request_wr[i]) begin
          owner = i; got_aw = 1'b0; got_w = 1'b0;
          break;
        end
      end
    end else if (!(got_aw && got_w)) begin
      if (m_axil_awvalid[owner] && s_axil_awready) got_aw = 1'b1;
      if (m_axil_wvalid[owner]  && s_axil_wready)  got_w  = 1'b1;
    end else if (s_axil_bvalid && m_axil_bready[owner]) begin
      owner = -1; got_aw = 1'b0; got_w = 1'b0;
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_grant;
    logic         in_addr;
    @(posedge aclk);
    model_edge();
    #1;
    exp_grant = (owner < 0) ? '0 : (N'(1) << owner);
    in_addr   = (owner >= 0) && !(got_aw && got_w);
    chk("grant_wr", 32'(grant_wr), 32'(exp_grant));
    chk("grant_wr_idx", 32'(grant_wr_idx), (owner < 0) ? 32'd0 : 32'(owner));
    chk("aw_open", 32'(aw_open), 32'(in_addr && !got_aw));
    chk("w_open", 32'(w_open), 32'(in_addr && !got_w));
  endtask

  initial begin
    aresetn = 1'b0;
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step(); step();
    chk("reset_grant", 32'(grant_wr), 32'd0);
    aresetn = 1'b1;

    // Idle for 10 cycles with no requests.
    for (int i = 0; i < 10; i++) step();

    // 1010: master 1 wins, AW+W together, B two cycles later.
    drive(4'b1010, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    chk("dir_grant_m1", 32'(grant_wr), 32'h2);
    drive(4'b1010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0, '0);
    step();
    chk("dir_opens_drop", 32'({aw_open, w_open}), 32'd0);
    drive(4'b1010, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    drive(4'b1010, '0, 1'b0, '0, 1'b0, 1'b1, 4'b0010);
    step();
    chk("dir_release", 32'(grant_wr), 32'd0);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();

    // Master 2: W first, AW three cycles later.
    drive(4'b0100, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    drive(4'b0100, '0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100);
    step();
    chk("dir_w_first", 32'({aw_open, w_open}), 32'b10);
    drive(4'b0100, '0, 1'b0, '0, 1'b0, 1'b1, 4'b0100);
    step(); step();
    chk("dir_bvalid_ignored_in_addr", 32'(grant_wr), 32'h4);
    drive(4'b0100, 4'b0100, 1'b1, '0, 1'b0, 1'b0, '0);
    step();
    drive('0, '0, 1'b0, '0, 1'b0, 1'b1, 4'b0100);
    step();
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();

    // Master 3 held while request_wr changes, then master 0 after one idle.
    drive(4'b1000, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    drive(4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0, '0);
    step();
    drive(4'b1001, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    chk("dir_hold_m3", 32'(grant_wr), 32'h8);
    drive(4'b1001, '0, 1'b0, '0, 1'b0, 1'b1, 4'b1000);
    step();
    drive(4'b1001, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();
    chk("dir_next_m0", 32'(grant_wr), 32'h1);
    drive('0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, '0);
    step();
    drive('0, '0, 1'b0, '0, 1'b0, 1'b1, 4'b0001);
    step();
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();

    // Master 1 in RESP: wrong bready for 3 cycles, then the right one.
    drive(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0, '0);
    step(); step();
    drive('0, '0, 1'b0, '0, 1'b0, 1'b1, 4'b0001);
    step(); step(); step();
    chk("dir_wrong_bready", 32'(grant_wr), 32'h2);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b1, 4'b0010);
    step();
    chk("dir_right_bready", 32'(grant_wr), 32'd0);
    drive('0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step();

    // Reset in RESP with master 2 granted, then a fresh grant.
    drive(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, '0);
    step(); step();
    drive(4'b0100, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    aresetn = 1'b0;
    step();
    chk("dir_reset_resp", 32'({grant_wr, grant_wr_idx, aw_open, w_open}), 32'd0);
    aresetn = 1'b1;
    step();
    chk("dir_regrant_opens", 32'({grant_wr, aw_open, w_open}), 32'b0100_11);
    drive('0, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, '0);
    step();
    drive('0, '0, 1'b0, '0, 1'b0, 1'b1, 4'b0100);
    step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      aresetn = ($urandom_range(0, 199) != 0);
      drive(($urandom_range(0, 3) == 0) ? '0 : N'($urandom),
            N'($urandom), 1'($urandom), N'($urandom), 1'($urandom),
            1'($urandom), N'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
